// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, bubble encoding, fetch FSM states.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_BUBBLE = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_pipe.sv
// IF/ID boundary register: flush inserts a bubble, hold freezes, load captures a fetched word.
module if_id_pipe
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            hold,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] inst,
    output logic            valid
);

    // Bubbles keep pc/pc4 so decode always sees the address of the last real instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            pc4   <= '0;
            inst  <= INST_BUBBLE;
            valid <= 1'b0;
        end else if (flush) begin
            inst  <= INST_BUBBLE;
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                pc    <= load_pc;
                pc4   <= load_pc + 32'd4;
                inst  <= load_inst;
                valid <= 1'b1;
            end else begin
                inst  <= INST_BUBBLE;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake, IF/ID register.
// Optional one-entry skid buffer for responses arriving under stall: IF_SKID_BUF_EN.
//
// state  | meaning
// F_IDLE | nothing outstanding
// F_WAIT | one request outstanding, response wanted
// F_DROP | one request outstanding, response to be discarded
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] inst,
    output logic            valid
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] target_aligned;
    logic            resp_want;
    logic            fire;
    logic            buf_block;
    logic            refetch;
    logic            pipe_load;
    logic [XLEN-1:0] pipe_pc;
    logic [XLEN-1:0] pipe_inst;

    assign target_aligned = branch_target & ~32'h3;
    assign resp_want      = (state == F_WAIT) && imem_rvalid;

`ifdef IF_SKID_BUF_EN
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_inst;

    assign buf_block = buf_valid && stall;
    assign refetch   = 1'b0;
    assign pipe_load = buf_valid || resp_want;
    assign pipe_pc   = buf_valid ? buf_pc : req_pc;
    assign pipe_inst = buf_valid ? buf_inst : imem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_inst  <= INST_BUBBLE;
        end else if (branch) begin
            buf_valid <= 1'b0;
        end else if (resp_want && stall) begin
            buf_valid <= 1'b1;
            buf_pc    <= req_pc;
            buf_inst  <= imem_rdata;
        end else if (!stall) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign buf_block = 1'b0;
    assign refetch   = resp_want && stall;
    assign pipe_load = resp_want;
    assign pipe_pc   = req_pc;
    assign pipe_inst = imem_rdata;
`endif

    // A new request may overlap the cycle its predecessor's response arrives.
    assign imem_req  = reset && !branch && !stall && !buf_block
                       && ((state == F_IDLE) || resp_want);
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE: if (fire) state_nxt = F_WAIT;
            F_WAIT: begin
                if (imem_rvalid)  state_nxt = fire ? F_WAIT : F_IDLE;
                else if (branch)  state_nxt = F_DROP;
            end
            F_DROP: if (imem_rvalid) state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (branch) begin
                fetch_pc <= target_aligned;
            end else if (fire) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end else if (refetch) begin
                fetch_pc <= req_pc;
            end
        end
    end

    if_id_pipe u_if_id_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (branch),
        .hold      (stall),
        .load      (pipe_load),
        .load_pc   (pipe_pc),
        .load_inst (pipe_inst),
        .pc        (pc),
        .pc4       (pc4),
        .inst      (inst),
        .valid     (valid)
    );

endmodule
